// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Optional checksum byte at the end of the stream is enabled by LOADER_CHECKSUM_EN.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_RST0,
    S_BURST,
    S_RST1,
    S_DONE
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // Data bytes plus the checksum byte must sum to this value (mod 256).
  localparam logic [7:0] CSUM_TARGET = 8'h00;

endpackage

// File: rtl/program_loader_if.sv
// Host byte-stream link: valid/ready handshake carrying one byte per transfer.
interface program_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, byte_data, input byte_ready);
  modport slave  (input byte_valid, byte_data, output byte_ready);
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words; first byte lands in [31:24].
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] hold_q, hold_d;

  // Shift the byte in and count position within the word.
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (clr_i) begin
      cnt_d  = '0;
      hold_d = '0;
    end else if (byte_valid_i) begin
      cnt_d  = cnt_q + 2'd1;
      hold_d = {hold_q[15:0], byte_data_i};
    end
  end

  // Byte counter and holding register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  // The last byte of a group completes the word in the same cycle.
  assign word_valid_o = byte_valid_i && !clr_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o       = {hold_q, byte_data_i};

endmodule

// File: rtl/program_loader.sv
// Program loader: collects a byte stream into a word buffer, then drives the
// CPU load interface (reset pulse, contiguous load burst, reset pulse).
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [AW:0]   word_count,
  program_loader_if.slave host,
  output logic          cpu_reset,
  output logic          cpu_load,
  output logic [31:0]   cpu_instr,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_e       state_q, state_d;
  logic [AW:0]  cnt_q, cnt_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [AW-1:0] ridx_q, ridx_d;
  logic         error_q, error_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  buf_q [DEPTH];

  logic         byte_ready;
  logic         fire;
  logic         wa_valid;
  logic         word_valid;
  logic [31:0]  word;
  logic         start_ok;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]   sum_q, sum_d;
  logic         csum_q, csum_d;
`endif

  assign fire     = host.byte_valid && byte_ready;
  assign start_ok = (word_count != '0) && (word_count <= DEPTH_W);

`ifdef LOADER_CHECKSUM_EN
  // The trailing checksum byte must not reach the assembler.
  assign wa_valid = fire && !csum_q;
`else
  assign wa_valid = fire;
`endif

  word_assembler u_wa (
    .clk          (clk),
    .Reset        (Reset),
    .clr_i        (state_q != S_COLLECT),
    .byte_valid_i (wa_valid),
    .byte_data_i  (host.byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // State and control registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      ridx_q  <= '0;
      error_q <= 1'b0;
      instr_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      csum_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      error_q <= error_d;
      instr_q <= instr_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      csum_q  <= csum_d;
`endif
    end
  end

  // Program buffer; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (word_valid) buf_q[widx_q] <= word;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    ridx_d  = '0;
    error_d = error_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (start_ok) begin
            cnt_d   = word_count;
            widx_d  = '0;
            error_d = 1'b0;
            state_d = S_COLLECT;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
            csum_d  = 1'b0;
`endif
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_COLLECT: begin
`ifdef LOADER_CHECKSUM_EN
        if (csum_q) begin
          if (fire) begin
            if (8'(sum_q + host.byte_data) == CSUM_TARGET) begin
              state_d = S_RST0;
            end else begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end else begin
          if (fire) sum_d = sum_q + host.byte_data;
          if (word_valid) begin
            widx_d = widx_q + 1'b1;
            if ({1'b0, widx_q} + ONE_W == cnt_q) csum_d = 1'b1;
          end
        end
`else
        if (word_valid) begin
          // widx wraps to 0 when the buffer is filled exactly.
          widx_d = widx_q + 1'b1;
          if ({1'b0, widx_q} + ONE_W == cnt_q) state_d = S_RST0;
        end
`endif
      end
      S_RST0: begin
        state_d = S_BURST;
      end
      S_BURST: begin
        if ({1'b0, ridx_q} + ONE_W == cnt_q) state_d = S_RST1;
        else ridx_d = ridx_q + 1'b1;
      end
      S_RST1: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Register the word for the cycle it is presented; zero outside the burst.
    instr_d = (state_d == S_BURST) ? buf_q[ridx_d] : '0;
  end

  // Outputs decoded from the registered state.
  always_comb begin
    cpu_reset  = (state_q == S_IDLE) || (state_q == S_RST0) || (state_q == S_RST1);
    cpu_load   = (state_q == S_BURST);
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    done       = (state_q == S_DONE);
    byte_ready = (state_q == S_COLLECT);
  end

  assign host.byte_ready = byte_ready;
  assign cpu_instr       = instr_q;
  assign error           = error_q;

endmodule
